ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
//  Shares the single-port data/instruction RAM between the IF-stage fetch port and the
//  MEM-stage load/store port (driven by RAM_Enable/RAM_RW/RAM_Size/RAM_SE from decode).
//  Registers the winning request, holds the RAM bus for a fixed access latency,
//  returns a one-cycle ack with read data, and raises stalls for waiting stages.
// PARAMETERS
//  ADDR_W     9   RAM byte-address width
//  MEM_LAT    2   cycles ram_en is held per access (>=1)
//  STARVE_MAX 3   consecutive MEM grants while IF waits before IF is forced to win (>=1)
// PORTS
//  clk          in   1       clock, all state updates on rising edge
//  rst_n        in   1       reset, synchronous, active-low
//  if_req       in   1       fetch request, held until if_ack
//  if_addr      in   ADDR_W  fetch byte address
//  if_ack       out  1       one-cycle pulse: fetch done, if_rdata valid
//  if_rdata     out  32      fetched instruction (held until next IF ack)
//  if_stall     out  1       if_req & ~if_ack (combinational)
//  mem_req      in   1       load/store request (RAM_Enable), held until mem_ack
//  mem_rw       in   1       0 = load, 1 = store
//  mem_size     in   2       00 byte, 01 half, 10 word
//  mem_se       in   1       sign-extend load data
//  mem_addr     in   ADDR_W  load/store byte address
//  mem_wdata    in   32      store data
//  mem_ack      out  1       one-cycle pulse: access done
//  mem_rdata    out  32      load data (0 for stores), held until next MEM ack
//  mem_stall    out  1       mem_req & ~mem_ack (combinational)
//  ram_en/ram_rw/ram_size/ram_se  out 1/1/2/1  registered RAM controls
//  ram_addr     out  ADDR_W  registered RAM address
//  ram_wdata    out  32      registered RAM write data
//  ram_rdata    in   32      RAM read data, valid in last cycle of access
//  misalign_err out  1       one-cycle pulse on rejected misaligned access
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): state IDLE, starve_cnt=0, lat_cnt=0, all outputs 0;
//    an in-flight access is abandoned without ack.
//  - FSM: IDLE -> GRANT_MEM | GRANT_IF -> IDLE. One idle turnaround cycle after every ack.
//  - IDLE arbitration: only one req -> grant it. Both -> MEM wins unless
//    starve_cnt==STARVE_MAX, then IF wins. starve_cnt++ on MEM grant while if_req=1
//    (saturating at STARVE_MAX); cleared on any IF grant.
//  - Grant edge: ram_* loaded from winner; IF grant forces rw=0,size=10,se=0,wdata=0.
//    ram_en=1 for exactly MEM_LAT cycles; lat_cnt counts 0..MEM_LAT-1.
//  - Last access cycle (lat_cnt==MEM_LAT-1): capture ram_rdata into requester's rdata
//    (0 for stores), pulse requester's ack next cycle together with ram_en->0, state IDLE.
//  - Latency: req seen in IDLE at edge N -> ack high in cycle N+MEM_LAT+1.
//    Throughput: one access per MEM_LAT+1 cycles.
//  - Req dropped mid-access: access completes, ack still pulsed. Req inputs changing
//    mid-access are ignored (fields latched at grant).
//  - Stall outputs are combinational from req and ack; never high while req=0.
// CONFIGURATION
//  ALIGN_CHECK_EN defined: at grant, misaligned access (size 10 & addr[1:0]!=0,
//    size 01 & addr[0]!=0; IF always checked as word) is rejected: ram_en stays 0,
//    next cycle ack=1, rdata=0, misalign_err=1 for one cycle, state IDLE. Counts as a
//    grant for starvation rules.
//  Undefined: no check, addresses forwarded unchanged; misalign_err tied 0.
// TESTING
//  1 IF only, MEM_LAT=2, if_addr=0x004, ram_rdata=0x00000013 -> ram_en high 2 cycles,
//    if_ack at grant+3, if_rdata=0x00000013, if_stall high 3 cycles.
//  2 Store mem_addr=0x010,size=10,wdata=0xDEADBEEF -> ram_rw=1,ram_wdata=0xDEADBEEF,
//    mem_ack with mem_rdata=0.
//  3 if_req and mem_req held high continuously -> grant sequence MEM,MEM,MEM,IF,MEM,...
//    (STARVE_MAX=3).
//  4 rst_n=0 during first access cycle -> next cycle all outputs 0, no ack; after
//    release, pending req regranted from IDLE.
//  5 ALIGN_CHECK_EN, LW mem_addr=0x013 -> ram_en never asserted, mem_ack=1,
//    misalign_err=1, mem_rdata=0; without macro, ram_addr=0x013 normal access.
//  6 mem_req dropped after grant -> access runs full MEM_LAT, mem_ack still pulsed once.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Arbiter sharing one single-port RAM between the IF fetch port and the MEM load/store port.
// Optional feature: define ALIGN_CHECK_EN to reject misaligned accesses at grant time.
module ram_port_arbiter #(
  parameter int ADDR_W     = 9,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  output logic              if_stall,
  input  logic              mem_req,
  input  logic              mem_rw,
  input  logic [1:0]        mem_size,
  input  logic              mem_se,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_ack,
  output logic [31:0]       mem_rdata,
  output logic              mem_stall,
  output logic              ram_en,
  output logic              ram_rw,
  output logic [1:0]        ram_size,
  output logic              ram_se,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              misalign_err
);

  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, GRANT_MEM, GRANT_IF} state_t;

  state_t            state_q, state_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [STV_W-1:0]  starve_q, starve_d;
  logic              ram_en_q, ram_en_d, ram_rw_q, ram_rw_d, ram_se_q, ram_se_d;
  logic [1:0]        ram_size_q, ram_size_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]       ram_wdata_q, ram_wdata_d;
  logic              if_ack_q, if_ack_d, mem_ack_q, mem_ack_d, misalign_q, misalign_d;
  logic [31:0]       if_rdata_q, if_rdata_d, mem_rdata_q, mem_rdata_d;
  logic              mem_mis, if_mis, grant_mem;

`ifdef ALIGN_CHECK_EN
  assign mem_mis = ((mem_size == 2'b10) && (mem_addr[1:0] != 2'b00)) ||
                   ((mem_size == 2'b01) && mem_addr[0]);
  assign if_mis  = (if_addr[1:0] != 2'b00);
`else
  assign mem_mis = 1'b0;
  assign if_mis  = 1'b0;
`endif

  // MEM has priority unless IF has already lost STARVE_MAX times in a row.
  assign grant_mem = mem_req && !(if_req && (starve_q == STV_W'(STARVE_MAX)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lat_q       <= '0;
      starve_q    <= '0;
      ram_en_q    <= 1'b0;
      ram_rw_q    <= 1'b0;
      ram_se_q    <= 1'b0;
      ram_size_q  <= 2'b00;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      misalign_q  <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      starve_q    <= starve_d;
      ram_en_q    <= ram_en_d;
      ram_rw_q    <= ram_rw_d;
      ram_se_q    <= ram_se_d;
      ram_size_q  <= ram_size_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
      misalign_q  <= misalign_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    starve_d    = starve_q;
    ram_en_d    = ram_en_q;
    ram_rw_d    = ram_rw_q;
    ram_se_d    = ram_se_q;
    ram_size_d  = ram_size_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    misalign_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_mem) begin
          if (if_req && (starve_q != STV_W'(STARVE_MAX))) starve_d = starve_q + STV_W'(1);
          ram_rw_d    = mem_rw;
          ram_size_d  = mem_size;
          ram_se_d    = mem_se;
          ram_addr_d  = mem_addr;
          ram_wdata_d = mem_wdata;
          if (mem_mis) begin
            mem_ack_d   = 1'b1;
            mem_rdata_d = '0;
            misalign_d  = 1'b1;
          end else begin
            state_d  = GRANT_MEM;
            ram_en_d = 1'b1;
            lat_d    = '0;
          end
        end else if (if_req) begin
          starve_d    = '0;
          ram_rw_d    = 1'b0;
          ram_size_d  = 2'b10;
          ram_se_d    = 1'b0;
          ram_addr_d  = if_addr;
          ram_wdata_d = '0;
          if (if_mis) begin
            if_ack_d   = 1'b1;
            if_rdata_d = '0;
            misalign_d = 1'b1;
          end else begin
            state_d  = GRANT_IF;
            ram_en_d = 1'b1;
            lat_d    = '0;
          end
        end
      end
      GRANT_MEM, GRANT_IF: begin
        if (lat_q == LAT_W'(MEM_LAT - 1)) begin
          ram_en_d = 1'b0;
          state_d  = IDLE;
          if (state_q == GRANT_MEM) begin
            mem_ack_d   = 1'b1;
            mem_rdata_d = ram_rw_q ? 32'h0 : ram_rdata;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = ram_rdata;
          end
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign if_ack       = if_ack_q;
  assign if_rdata     = if_rdata_q;
  assign if_stall     = if_req & ~if_ack_q;
  assign mem_ack      = mem_ack_q;
  assign mem_rdata    = mem_rdata_q;
  assign mem_stall    = mem_req & ~mem_ack_q;
  assign ram_en       = ram_en_q;
  assign ram_rw       = ram_rw_q;
  assign ram_size     = ram_size_q;
  assign ram_se       = ram_se_q;
  assign ram_addr     = ram_addr_q;
  assign ram_wdata    = ram_wdata_q;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter at default parameters (MEM_LAT=2, STARVE_MAX=3).
module tb_ram_port_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [8:0]  if_addr = '0;
  logic        if_ack, if_stall, mem_ack, mem_stall;
  logic [31:0] if_rdata, mem_rdata;
  logic        mem_req = 1'b0, mem_rw = 1'b0, mem_se = 1'b0;
  logic [1:0]  mem_size = 2'b00;
  logic [8:0]  mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        ram_en, ram_rw, ram_se, misalign_err;
  logic [1:0]  ram_size;
  logic [8:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;
  int tests_run = 0;
  int tests_failed = 0;

  ram_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_stall(if_stall),
    .mem_req(mem_req), .mem_rw(mem_rw), .mem_size(mem_size), .mem_se(mem_se),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_stall(mem_stall), .ram_en(ram_en), .ram_rw(ram_rw), .ram_size(ram_size),
    .ram_se(ram_se), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    tests_run++; if (ram_en !== 1'b0) begin tests_failed++; $display("FAIL rst_ram_en: got %0h exp 0", ram_en); end
    tests_run++; if (ram_addr !== 9'h0) begin tests_failed++; $display("FAIL rst_ram_addr: got %0h exp 0", ram_addr); end
    tests_run++; if ({if_ack, mem_ack, misalign_err, if_stall, mem_stall} !== 5'b0) begin tests_failed++; $display("FAIL rst_flags: got %b exp 00000", {if_ack, mem_ack, misalign_err, if_stall, mem_stall}); end
    tests_run++; if ({if_rdata, mem_rdata, ram_wdata} !== 96'h0) begin tests_failed++; $display("FAIL rst_data: got %h exp 0", {if_rdata, mem_rdata, ram_wdata}); end
    rst_n = 1'b1;
    tick();
    $display("[TB] reset done");
  endtask

  task automatic test_if_fetch();
    int stall_cycles = 0;
    if_req = 1'b1; if_addr = 9'h004; ram_rdata = 32'hBAD0BAD0;
    #1 stall_cycles += int'(if_stall);
    tick();
    stall_cycles += int'(if_stall);
    tests_run++; if ({ram_en, ram_rw, ram_size, ram_se} !== 5'b10100) begin tests_failed++; $display("FAIL if_grant_ctl: got %b exp 10100", {ram_en, ram_rw, ram_size, ram_se}); end
    tests_run++; if (ram_addr !== 9'h004) begin tests_failed++; $display("FAIL if_grant_addr: got %h exp 004", ram_addr); end
    tick();
    stall_cycles += int'(if_stall);
    tests_run++; if ({ram_en, if_ack} !== 2'b10) begin tests_failed++; $display("FAIL if_cycle2: got en/ack %b exp 10", {ram_en, if_ack}); end
    ram_rdata = 32'h00000013;
    tick();
    stall_cycles += int'(if_stall);
    tests_run++; if ({ram_en, if_ack} !== 2'b01) begin tests_failed++; $display("FAIL if_ack_cycle: got en/ack %b exp 01", {ram_en, if_ack}); end
    tests_run++; if (if_rdata !== 32'h00000013) begin tests_failed++; $display("FAIL if_rdata: got %h exp 00000013", if_rdata); end
    if_req = 1'b0; ram_rdata = 32'hFFFFFFFF;
    tick();
    tests_run++; if ({ram_en, if_ack, if_rdata} !== {2'b00, 32'h00000013}) begin tests_failed++; $display("FAIL if_after: got en/ack %b rdata %h exp 00/00000013", {ram_en, if_ack}, if_rdata); end
    tests_run++; if (stall_cycles != 3) begin tests_failed++; $display("FAIL if_stall_cycles: got %0d exp 3", stall_cycles); end
    $display("[TB] IF fetch addr=004 rdata=%h", if_rdata);
  endtask

  task automatic test_load();
    mem_req = 1'b1; mem_rw = 1'b0; mem_size = 2'b10; mem_se = 1'b1; mem_addr = 9'h020;
    ram_rdata = 32'h11111111;
    tick();
    tests_run++; if ({ram_en, ram_rw, ram_size, ram_se, ram_addr} !== {5'b10101, 9'h020}) begin tests_failed++; $display("FAIL ld_grant: got %b/%h exp 10101/020", {ram_en, ram_rw, ram_size, ram_se}, ram_addr); end
    tick();
    ram_rdata = 32'hCAFEF00D;
    tick();
    tests_run++; if ({mem_ack, mem_rdata} !== {1'b1, 32'hCAFEF00D}) begin tests_failed++; $display("FAIL ld_ack: got ack %b rdata %h exp 1/cafef00d", mem_ack, mem_rdata); end
    mem_req = 1'b0;
    tick();
    $display("[TB] MEM load addr=020 rdata=%h", mem_rdata);
  endtask

  task automatic test_store();
    mem_req = 1'b1; mem_rw = 1'b1; mem_size = 2'b10; mem_se = 1'b0; mem_addr = 9'h010;
    mem_wdata = 32'hDEADBEEF; ram_rdata = 32'h12345678;
    tick();
    tests_run++; if ({ram_en, ram_rw, ram_wdata, ram_addr} !== {2'b11, 32'hDEADBEEF, 9'h010}) begin tests_failed++; $display("FAIL st_grant: got en/rw %b wdata %h addr %h exp 11/deadbeef/010", {ram_en, ram_rw}, ram_wdata, ram_addr); end
    tick(); tick();
    tests_run++; if ({mem_ack, mem_rdata} !== {1'b1, 32'h0}) begin tests_failed++; $display("FAIL st_ack: got ack %b rdata %h exp 1/0", mem_ack, mem_rdata); end
    mem_req = 1'b0;
    tick();
    $display("[TB] MEM store addr=010 wdata=deadbeef");
  endtask

  task automatic test_back_to_back();
    logic [5:0] seq = '0;
    logic prev_en = 1'b0;
    int n = 0;
    int last_cyc = 0;
    int spacing_bad = 0;
    mem_req = 1'b1; mem_rw = 1'b0; mem_size = 2'b10; mem_addr = 9'h040;
    if_req = 1'b1; if_addr = 9'h080;
    for (int c = 1; c <= 40 && n < 6; c++) begin
      tick();
      if (ram_en && !prev_en) begin
        seq[5-n] = (ram_addr == 9'h040);
        if (n > 0 && (c - last_cyc) != 3) spacing_bad++;
        last_cyc = c;
        n++;
      end
      prev_en = ram_en;
    end
    tests_run++; if (n != 6) begin tests_failed++; $display("FAIL b2b_grant_count: got %0d exp 6", n); end
    tests_run++; if (seq !== 6'b111011) begin tests_failed++; $display("FAIL b2b_sequence: got %b exp 111011 (1=MEM)", seq); end
    tests_run++; if (spacing_bad != 0) begin tests_failed++; $display("FAIL b2b_spacing: got %0d bad gaps exp 0", spacing_bad); end
    mem_req = 1'b0; if_req = 1'b0;
    tick(); tick(); tick(); tick();
    $display("[TB] back-to-back grants %b", seq);
  endtask

  task automatic test_reset_mid();
    mem_req = 1'b1; mem_rw = 1'b0; mem_size = 2'b10; mem_addr = 9'h030;
    ram_rdata = 32'h77777777;
    tick();
    tests_run++; if (ram_en !== 1'b1) begin tests_failed++; $display("FAIL rmid_grant: got %b exp 1", ram_en); end
    rst_n = 1'b0;
    tick();
    tests_run++; if ({ram_en, mem_ack, ram_addr, mem_rdata, if_rdata} !== 75'h0) begin tests_failed++; $display("FAIL rmid_cleared: en %b ack %b addr %h mrd %h ird %h exp all 0", ram_en, mem_ack, ram_addr, mem_rdata, if_rdata); end
    rst_n = 1'b1;
    tick();
    tests_run++; if ({ram_en, ram_addr} !== {1'b1, 9'h030}) begin tests_failed++; $display("FAIL rmid_regrant: got en %b addr %h exp 1/030", ram_en, ram_addr); end
    tick(); tick();
    tests_run++; if ({mem_ack, mem_rdata} !== {1'b1, 32'h77777777}) begin tests_failed++; $display("FAIL rmid_ack: got ack %b rdata %h exp 1/77777777", mem_ack, mem_rdata); end
    mem_req = 1'b0;
    tick();
    $display("[TB] reset mid-access regrant rdata=%h", mem_rdata);
  endtask

  task automatic test_misalign();
    mem_req = 1'b1; mem_rw = 1'b0; mem_size = 2'b10; mem_addr = 9'h013;
    ram_rdata = 32'h00000055;
    tick();
`ifdef ALIGN_CHECK_EN
    tests_run++; if ({ram_en, mem_ack, misalign_err, mem_rdata} !== {3'b011, 32'h0}) begin tests_failed++; $display("FAIL mis_reject: got en/ack/err %b rdata %h exp 011/0", {ram_en, mem_ack, misalign_err}, mem_rdata); end
    mem_req = 1'b0;
    tick();
    tests_run++; if ({ram_en, mem_ack, misalign_err} !== 3'b000) begin tests_failed++; $display("FAIL mis_after: got %b exp 000", {ram_en, mem_ack, misalign_err}); end
`else
    tests_run++; if ({ram_en, ram_addr, misalign_err} !== {1'b1, 9'h013, 1'b0}) begin tests_failed++; $display("FAIL mis_forward: got en %b addr %h err %b exp 1/013/0", ram_en, ram_addr, misalign_err); end
    tick(); tick();
    tests_run++; if ({mem_ack, mem_rdata, misalign_err} !== {1'b1, 32'h00000055, 1'b0}) begin tests_failed++; $display("FAIL mis_ack: got ack %b rdata %h err %b exp 1/00000055/0", mem_ack, mem_rdata, misalign_err); end
    mem_req = 1'b0;
    tick();
`endif
    $display("[TB] LW addr=013 rdata=%h", mem_rdata);
  endtask

  task automatic test_drop_req();
    int acks = 0;
    mem_req = 1'b1; mem_rw = 1'b0; mem_size = 2'b10; mem_addr = 9'h008;
    ram_rdata = 32'hA5A5A5A5;
    tick();
    mem_req = 1'b0; mem_addr = 9'h1FC;
    #1;
    tests_run++; if (mem_stall !== 1'b0) begin tests_failed++; $display("FAIL drop_stall: got %b exp 0", mem_stall); end
    tick();
    tests_run++; if ({ram_en, ram_addr} !== {1'b1, 9'h008}) begin tests_failed++; $display("FAIL drop_latched: got en %b addr %h exp 1/008", ram_en, ram_addr); end
    for (int c = 0; c < 5; c++) begin
      tick();
      acks += int'(mem_ack);
      if (c == 0) begin
        tests_run++; if ({mem_ack, mem_rdata} !== {1'b1, 32'hA5A5A5A5}) begin tests_failed++; $display("FAIL drop_ack: got ack %b rdata %h exp 1/a5a5a5a5", mem_ack, mem_rdata); end
      end
    end
    tests_run++; if (acks != 1) begin tests_failed++; $display("FAIL drop_ack_count: got %0d exp 1", acks); end
    $display("[TB] dropped req access rdata=%h acks=%0d", mem_rdata, acks);
  endtask

  initial begin
    test_reset();
    test_if_fetch();
    test_load();
    test_store();
    test_back_to_back();
    test_reset_mid();
    test_misalign();
    test_drop_req();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
